// File: rtl/obuf_ld_beat_splitter.sv
// OBUF load-path beat splitter: holds one DDR read beat and writes it out
// as RATIO consecutive bank rows at incrementing OBUF row addresses.
module obuf_ld_beat_splitter #(
  parameter int DDR_BANDWIDTH = 512,
  parameter int NUM_BANKS     = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 10,
  parameter int BEATS_WIDTH   = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [BEATS_WIDTH-1:0]          num_beats,
  output logic                            busy,
  output logic                            done,
  input  logic [DDR_BANDWIDTH-1:0]        s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic                            bank_wr_en,
  output logic [ADDR_WIDTH-1:0]           bank_wr_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] bank_wr_data
);

  localparam int RW    = NUM_BANKS * DATA_WIDTH;
  localparam int RATIO = DDR_BANDWIDTH / RW;
  localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [SW-1:0] LAST = SW'(RATIO - 1);
  localparam bit R1 = (RATIO == 1);

  localparam logic [BEATS_WIDTH-1:0] B0 = '0;
  localparam logic [BEATS_WIDTH-1:0] B1 = BEATS_WIDTH'(1);
  localparam logic [BEATS_WIDTH-1:0] B2 = BEATS_WIDTH'(2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                   state;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [BEATS_WIDTH-1:0]   beats_left;
  logic [SW-1:0]            sub_cnt;
  logic [RATIO-1:0][RW-1:0] beat_q;
  logic                     take;

  assign take = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      beats_left   <= '0;
      sub_cnt      <= '0;
      beat_q       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      s_ready      <= 1'b0;
      bank_wr_en   <= 1'b0;
      bank_wr_addr <= '0;
      bank_wr_data <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr_q     <= base_addr;
            beats_left <= num_beats;
            busy       <= 1'b1;
            if (num_beats == B0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state   <= S_WAIT;
              s_ready <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (take) begin
            beat_q       <= s_data;
            sub_cnt      <= '0;
            state        <= S_DRAIN;
            bank_wr_en   <= 1'b1;
            bank_wr_addr <= addr_q;
            addr_q       <= addr_q + 1'b1;
            bank_wr_data <= s_data[RW-1:0];
            s_ready      <= R1 && (beats_left > B1);
          end
        end
        S_DRAIN: begin
          if (sub_cnt != LAST) begin
            sub_cnt      <= sub_cnt + SW'(1);
            bank_wr_addr <= addr_q;
            addr_q       <= addr_q + 1'b1;
            bank_wr_data <= beat_q[sub_cnt + SW'(1)];
            s_ready      <= (sub_cnt + SW'(1) == LAST) && (beats_left > B1);
          end else begin
            beats_left <= beats_left - B1;
            if (beats_left == B1) begin
              state      <= S_DONE;
              done       <= 1'b1;
              bank_wr_en <= 1'b0;
              s_ready    <= 1'b0;
            end else if (take) begin
              // next beat lands in the same cycle as the last row: no bubble
              beat_q       <= s_data;
              sub_cnt      <= '0;
              bank_wr_addr <= addr_q;
              addr_q       <= addr_q + 1'b1;
              bank_wr_data <= s_data[RW-1:0];
              s_ready      <= R1 && (beats_left > B2);
            end else begin
              state      <= S_WAIT;
              bank_wr_en <= 1'b0;
              s_ready    <= 1'b1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obuf_ld_beat_splitter.sv
// Bench for obuf_ld_beat_splitter: a transaction-schedule model predicts
// every output each cycle; directed runs pin the model with literal values.
module tb_obuf_ld_beat_splitter;

  localparam int DB = 512;
  localparam int NB = 8;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int BW = 16;
  localparam int RW = NB * DW;
  localparam int R  = DB / RW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [BW-1:0] num_beats = '0;
  logic          busy, done;
  logic [DB-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          bank_wr_en;
  logic [AW-1:0] bank_wr_addr;
  logic [RW-1:0] bank_wr_data;

  obuf_ld_beat_splitter dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .num_beats(num_beats),
    .busy(busy), .done(done),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .bank_wr_en(bank_wr_en), .bank_wr_addr(bank_wr_addr),
    .bank_wr_data(bank_wr_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 0;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [RW-1:0] d;
  } wr_t;

  // model state: scheduled row writes plus transfer bookkeeping
  wr_t           wq[$];
  bit            xfer_on = 0;
  int            to_acc = 0;
  int            last_wr = 0;
  int            done_cyc = -1;
  logic [AW-1:0] m_addr = '0;
  logic [AW-1:0] h_addr = '0;
  logic [RW-1:0] h_data = '0;

  // observation logs for directed literal checks
  logic [AW-1:0] la[$];
  logic [RW-1:0] ld[$];
  int            lc[$];
  int            n_done, n_rdy, c_done;

  task automatic chk(input string nm, input logic [DB-1:0] a,
                     input logic [DB-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, a, e);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (chk_en) begin
      bit e_en, e_rdy;
      e_en  = (wq.size() > 0) && (wq[0].c == cyc);
      e_rdy = xfer_on && (to_acc > 0) && (last_wr <= cyc);
      if (e_en) begin
        h_addr = wq[0].a;
        h_data = wq[0].d;
        void'(wq.pop_front());
      end
      chk("busy", busy, xfer_on);
      chk("done", done, xfer_on && (done_cyc == cyc));
      chk("s_ready", s_ready, e_rdy);
      chk("wr_en", bank_wr_en, e_en);
      chk("wr_addr", bank_wr_addr, h_addr);
      chk("wr_data", bank_wr_data, h_data);
      if (bank_wr_en === 1'b1) begin
        la.push_back(bank_wr_addr);
        ld.push_back(bank_wr_data);
        lc.push_back(cyc);
      end
      if (done === 1'b1) begin
        n_done++;
        c_done = cyc;
      end
      if (s_ready === 1'b1) n_rdy++;
      if (reset) begin
        wq.delete();
        xfer_on  = 0;
        to_acc   = 0;
        done_cyc = -1;
        h_addr   = '0;
        h_data   = '0;
      end else if (xfer_on && done_cyc == cyc) begin
        xfer_on = 0;
      end else if (!xfer_on && start) begin
        xfer_on = 1;
        to_acc  = num_beats;
        m_addr  = base_addr;
        last_wr = cyc;
        done_cyc = (num_beats == 0) ? cyc + 1 : -1;
      end else if (e_rdy && s_valid) begin
        for (int k = 0; k < R; k++) begin
          wq.push_back('{c: cyc + 1 + k, a: m_addr, d: s_data[k*RW +: RW]});
          m_addr++;
        end
        last_wr = cyc + R;
        to_acc--;
        if (to_acc == 0) done_cyc = cyc + R + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DB-1:0] rnd_beat();
    logic [DB-1:0] v;
    for (int i = 0; i < DB / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // one transfer; valid is forced low in [qlo,qhi), start re-pulsed at
  // cycle poke, reset pulsed at cycle rst_at (negative = never)
  task automatic run(input logic [AW-1:0] base, input int num,
                     input int gap, input int qlo, input int qhi,
                     input int poke, input int rst_at,
                     input bit fix, input logic [DB-1:0] fdat);
    int i, budget;
    la.delete();
    ld.delete();
    lc.delete();
    n_done = 0;
    n_rdy  = 0;
    c_done = -1;
    budget = num * R * 20 + 50;
    tick();
    start     = 1'b1;
    base_addr = base;
    num_beats = BW'(num);
    tick();
    start = 1'b0;
    i = 0;
    while (xfer_on && i < budget) begin
      s_valid = ($urandom_range(99) >= gap) && !(i >= qlo && i < qhi);
      s_data  = fix ? fdat : rnd_beat();
      start   = (i == poke);
      base_addr = AW'($urandom);
      num_beats = BW'($urandom_range(7));
      reset   = (i == rst_at);
      tick();
      i++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    reset   = 1'b0;
    if (i >= budget) begin
      total++;
      bad++;
      $display("FAIL timeout base=%0h num=%0d", base, num);
    end
    repeat (2) tick();
  endtask

  initial begin
    logic [DB-1:0] cnt;
    for (int k = 0; k < DB / 8; k++) cnt[k*8 +: 8] = 8'(k);

    @(posedge clk);
    #1;
    chk_en = 1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // single beat with counting bytes
    run(10'h010, 1, 0, 0, 0, -1, -1, 1, cnt);
    chk("t1_nwr", la.size(), 8);
    chk("t1_a0", la[0], 10'h010);
    chk("t1_a7", la[7], 10'h017);
    chk("t1_r3b0", ld[3][7:0], 8'h18);
    chk("t1_r3b7", ld[3][63:56], 8'h1f);
    chk("t1_ndone", n_done, 1);
    chk("t1_dlat", c_done - lc[7], 1);

    // streaming, valid always high
    run(10'h000, 4, 0, 0, 0, -1, -1, 0, '0);
    chk("t2_nwr", la.size(), 32);
    chk("t2_span", lc[31] - lc[0], 31);
    chk("t2_a31", la[31], 10'h01f);
    chk("t2_nrdy", n_rdy, 4);

    // second beat held off for five WAIT cycles
    run(10'h120, 2, 0, 1, 14, -1, -1, 0, '0);
    chk("t3_nwr", la.size(), 16);
    chk("t3_a8", la[8], 10'h128);
    chk("t3_span", lc[15] - lc[0], 21);
    chk("t3_dlat", c_done - lc[15], 1);

    // address wrap
    run(10'h3fc, 1, 0, 0, 0, -1, -1, 0, '0);
    chk("t4_a3", la[3], 10'h3ff);
    chk("t4_a4", la[4], 10'h000);
    chk("t4_a7", la[7], 10'h003);

    // zero length
    run(10'h055, 0, 30, 0, 0, -1, -1, 0, '0);
    chk("t5_nwr", la.size(), 0);
    chk("t5_ndone", n_done, 1);
    chk("t5_nrdy", n_rdy, 0);

    // start pulse in the middle of DRAIN is ignored
    run(10'h200, 2, 0, 0, 0, 4, -1, 0, '0);
    chk("t6_nwr", la.size(), 16);
    chk("t6_a15", la[15], 10'h20f);

    // reset after the third write, then a clean transfer
    run(10'h040, 2, 0, 0, 0, -1, 3, 0, '0);
    chk("t7_nwr", la.size(), 3);
    chk("t7_ndone", n_done, 0);
    run(10'h080, 1, 0, 0, 0, -1, -1, 0, '0);
    chk("t7b_nwr", la.size(), 8);
    chk("t7b_a0", la[0], 10'h080);
    chk("t7b_ndone", n_done, 1);

    // randomized transfers
    for (int t = 0; t < 25; t++) begin
      run(AW'($urandom), $urandom_range(5), $urandom_range(60),
          0, 0, ($urandom_range(3) == 0) ? $urandom_range(20) : -1,
          -1, 0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
